serial_subtract_ctrl: RTL

//  Bit-serial subtractor controller: computes a - b - bin on WIDTH-bit operands by sequencing one

---
 rtl/serial_subtract_ctrl_pkg.sv | 18 +
 rtl/serial_subtract_ctrl_full_subtractor.sv | 13 +
 rtl/serial_subtract_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/serial_subtract_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller:
// FSM state encodings and the operand-width legality rule.
package serial_subtract_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    function automatic bit width_legal(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/serial_subtract_ctrl_full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, bout = borrow out.
module serial_subtract_ctrl_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor controller: a - b - bin, LSB first, one bit per clock
// through a single full-subtractor cell with the borrow carried in a flop.
module serial_subtract_ctrl
    import serial_subtract_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH);

    generate
        if (!width_legal(WIDTH)) begin : g_width_check
            $error("serial_subtract_ctrl: WIDTH must be within 2..32");
        end
    endgenerate

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             borrow;
    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

    serial_subtract_ctrl_full_subtractor u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (borrow),
        .diff (cell_d),
        .bout (cell_bo)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // abort has priority over finishing the last bit
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (last_bit) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign busy = ~ready;
    assign diff = diff_q;
    assign bout = bout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            borrow <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        sd     <= '0;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        cnt    <= '0;
                        sa     <= '0;
                        sb     <= '0;
                        sd     <= '0;
                        borrow <= 1'b0;
                    end else begin
                        sd     <= {cell_d, sd[WIDTH-1:1]};
                        sa     <= sa >> 1;
                        sb     <= sb >> 1;
                        borrow <= cell_bo;
                        // hold the count on the final bit so it never wraps
                        if (last_bit) begin
                            diff_q <= {cell_d, sd[WIDTH-1:1]};
                            bout_q <= cell_bo;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    a_done_single: assert property (@(posedge clk) disable iff (rst) done |=> !done);
    a_cnt_range:   assert property (@(posedge clk) disable iff (rst)
                                    (state == ST_SHIFT) |-> (cnt <= CNT_W'(WIDTH - 1)));

endmodule
